// File: rtl/sram_bank_arbiter_if.sv
// Requester and SRAM-side signal bundle of the bank arbiter.
// slave = arbiter side, master = requesters plus SRAM macro.
interface sram_bank_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            we_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ*BW-1:0]         be_i;
  logic [NUM_REQ-1:0]            lock_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]         rdata_o;
  logic                          sram_cs_o;
  logic                          sram_we_o;
  logic [ADDR_WIDTH-1:0]         sram_addr_o;
  logic [BW-1:0]                 sram_be_o;
  logic [DATA_WIDTH-1:0]         sram_wdata_o;
  logic [DATA_WIDTH-1:0]         sram_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, lock_i,
    input  sram_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output sram_cs_o, sram_we_o, sram_addr_o,
    output sram_be_o, sram_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, lock_i,
    output sram_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  sram_cs_o, sram_we_o, sram_addr_o,
    input  sram_be_o, sram_wdata_o
  );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter sharing one SRAM bank among NUM_REQ requesters.
// Define SRAM_ARB_LOCK_EN for bounded grant locking (atomic bursts).
module sram_bank_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int MAX_LOCK     = 8
) (
  input logic                clk_i,
  input logic                rst_ni,
  sram_bank_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam int TD = READ_LATENCY + 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         rr_sel;
  logic                  rr_hit;
  logic [IW-1:0]         cand;
  logic [IW-1:0]         gsel;
  logic                  gv;
  logic [NUM_REQ-1:0]    gnt;
  logic                  acc;
  logic                  lock_out;
  logic [IW-1:0]         own;

  logic                  cs_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]         be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [TD-1:0]         tv_q;
  logic [IW-1:0]         tidx_q [TD];

  // First requester at or after the round-robin pointer
  always_comb begin
    rr_sel = '0;
    rr_hit = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!rr_hit && bus.req_i[cand]) begin
        rr_hit = 1'b1;
        rr_sel = cand;
      end
    end
  end

  // Grant: owner only while locked, else round-robin pick
  always_comb begin
    gnt  = '0;
    gsel = rr_sel;
    gv   = rr_hit;
    if (lock_out) begin
      gsel = own;
      gv   = bus.req_i[own];
    end
    if (gv && rst_ni) gnt[gsel] = 1'b1;
  end

  assign acc       = |(gnt & bus.req_i);
  assign bus.gnt_o = gnt;

`ifdef SRAM_ARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lk_e;
  lk_e           st_q;
  logic [IW-1:0] own_q;
  logic [CW-1:0] cnt_q;

  assign lock_out = (st_q == LOCKED);
  assign own      = own_q;

  // Lock FSM: bounded run of owner grants
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q  <= UNLOCKED;
      own_q <= '0;
      cnt_q <= '0;
    end else begin
      unique case (st_q)
        UNLOCKED: begin
          if (acc && bus.lock_i[gsel] && MAX_LOCK > 1) begin
            st_q  <= LOCKED;
            own_q <= gsel;
            cnt_q <= CW'(1);
          end
        end
        LOCKED: begin
          if (!bus.req_i[own_q] || !bus.lock_i[own_q] ||
              int'(cnt_q) + 1 >= MAX_LOCK) begin
            st_q  <= UNLOCKED;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: st_q <= UNLOCKED;
      endcase
    end
  end
`else
  assign lock_out = 1'b0;
  assign own      = '0;
  wire [CW-1:0] unused_lock = {CW{^bus.lock_i}};
`endif

  // Round-robin pointer advances past each accepted requester
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else if (acc) ptr_q <= IW'((int'(gsel) + 1) % NUM_REQ);
  end

  // Registered SRAM strobes; addr/wdata hold when idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      cs_q <= acc;
      we_q <= acc & bus.we_i[gsel];
      be_q <= acc ? bus.be_i[gsel*BW +: BW] : '0;
      if (acc) begin
        addr_q  <= bus.addr_i[gsel*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= bus.wdata_i[gsel*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Tag pipe routes each read result back to its issuer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tv_q <= '0;
      for (int i = 0; i < TD; i++) tidx_q[i] <= '0;
    end else begin
      tv_q[0]   <= acc & ~bus.we_i[gsel];
      tidx_q[0] <= gsel;
      for (int i = 1; i < TD; i++) begin
        tv_q[i]   <= tv_q[i-1];
        tidx_q[i] <= tidx_q[i-1];
      end
    end
  end

  assign bus.sram_cs_o    = cs_q;
  assign bus.sram_we_o    = we_q;
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_be_o    = be_q;
  assign bus.sram_wdata_o = wdata_q;

  assign bus.rvalid_o = tv_q[TD-1] ?
    (NUM_REQ'(1) << tidx_q[TD-1]) : '0;
  assign bus.rdata_o  = tv_q[TD-1] ?
    bus.sram_rdata_i : '0;
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with SRAM model
// and a read-return scoreboard.
module tb_sram_bank_arbiter;
  localparam int NR  = 2;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int ML  = 3;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   nret = 0;
  exp_t sbq [$];

  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic [31:0] line [LAT];
  logic        mem_init = 1'b0;
  logic        sh_init = 1'b0;

  sram_bank_arbiter_if #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  sram_bank_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .READ_LATENCY(LAT), .MAX_LOCK(ML)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input int i);
    return 32'hA5A50000 ^ (i * 32'h01030507);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // SRAM model: reads appear LAT cycles after cs
  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= memf(i);
      mem_init <= 1'b1;
    end else if (bus.sram_cs_o && bus.sram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_be_o[b])
          mem[bus.sram_addr_o[7:0]][b*8 +: 8] <=
            bus.sram_wdata_o[b*8 +: 8];
    end
    line[0] <= (bus.sram_cs_o && !bus.sram_we_o) ?
      mem[bus.sram_addr_o[7:0]] : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) line[i] <= line[i-1];
  end

  assign bus.sram_rdata_i = line[LAT-1];

  // Scoreboard: push on read accept, pop on rvalid
  always @(negedge clk_i) begin
    if (!sh_init) begin
      for (int i = 0; i < 256; i++) shadow[i] = memf(i);
      sh_init = 1'b1;
    end
    if (rst_ni) begin
      if (bus.rvalid_o != '0) begin
        nret++;
        if (sbq.size() == 0) begin
          chk("ret_unexp", 64'(bus.rvalid_o), 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("ret_idx", 64'(bus.rvalid_o), 64'(1 << e.idx));
          chk("ret_data", 64'(bus.rdata_o), 64'(e.data));
          chk("ret_cyc", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("rdata_idle", 64'(bus.rdata_o), 64'd0);
        if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
          chk("ret_miss", 64'(cyc), 64'(sbq[0].cyc + 1000));
          void'(sbq.pop_front());
        end
      end
      for (int k = 0; k < NR; k++) begin
        if (bus.req_i[k] && bus.gnt_o[k]) begin
          int a;
          a = int'(bus.addr_i[k*AW +: 8]);
          if (bus.we_i[k]) begin
            for (int b = 0; b < 4; b++)
              if (bus.be_i[k*4 + b])
                shadow[a][b*8 +: 8] =
                  bus.wdata_i[k*DW + b*8 +: 8];
          end else begin
            exp_t n;
            n.idx  = k;
            n.data = shadow[a];
            n.cyc  = cyc + 1 + LAT;
            sbq.push_back(n);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic clr();
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.lock_i  = '0;
  endtask

  task automatic setreq(input int k, input logic we,
                        input logic [15:0] a,
                        input logic [31:0] d,
                        input logic lk);
    bus.req_i[k]            = 1'b1;
    bus.we_i[k]             = we;
    bus.addr_i[k*AW +: AW]  = a;
    bus.wdata_i[k*DW +: DW] = d;
    bus.be_i[k*4 +: 4]      = 4'hF;
    bus.lock_i[k]           = lk;
  endtask

  task automatic do_reset();
    clr();
    rst_ni = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Watchdog keeps any stall from hanging the run
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] g2 [4];
    logic [1:0] g5 [5];
    int n0;
    clr();
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.be_i    = '0;
    bus.req_i[0] = 1'b1;
    smp();
    smp();
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rst_cs", 64'(bus.sram_cs_o), 64'd0);
    chk("rst_we", 64'(bus.sram_we_o), 64'd0);
    chk("rst_addr", 64'(bus.sram_addr_o), 64'd0);
    chk("rst_be", 64'(bus.sram_be_o), 64'd0);
    chk("rst_rv", 64'(bus.rvalid_o), 64'd0);
    chk("rst_rd", 64'(bus.rdata_o), 64'd0);
    do_reset();

    // single read, latency
    tick();
    setreq(0, 1'b0, 16'h0010, 32'h0, 1'b0);
    smp();
    chk("t1_gnt", 64'(bus.gnt_o), 64'h1);
    tick();
    clr();
    smp();
    chk("t1_cs", 64'(bus.sram_cs_o), 64'h1);
    chk("t1_addr", 64'(bus.sram_addr_o), 64'h10);
    chk("t1_we", 64'(bus.sram_we_o), 64'h0);
    tick();
    smp();
    chk("t1_rv_t2", 64'(bus.rvalid_o), 64'h0);
    tick();
    smp();
    chk("t1_rv_t3", 64'(bus.rvalid_o), 64'h1);
    chk("t1_rd", 64'(bus.rdata_o), 64'(memf(16)));

    // continuous round-robin
    do_reset();
    g2[0] = 2'b01; g2[1] = 2'b10;
    g2[2] = 2'b01; g2[3] = 2'b10;
    tick();
    setreq(0, 1'b0, 16'h0040, 32'h0, 1'b0);
    setreq(1, 1'b0, 16'h0041, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      smp();
      chk($sformatf("t2_gnt%0d", i),
          64'(bus.gnt_o), 64'(g2[i]));
      if (i > 0)
        chk($sformatf("t2_cs%0d", i),
            64'(bus.sram_cs_o), 64'h1);
    end
    tick();
    clr();
    smp();
    chk("t2_cs_last", 64'(bus.sram_cs_o), 64'h1);
    repeat (5) tick();

    // write then read back
    setreq(0, 1'b1, 16'h0020, 32'hDEADBEEF, 1'b0);
    smp();
    chk("t3_wgnt", 64'(bus.gnt_o), 64'h1);
    tick();
    setreq(0, 1'b0, 16'h0020, 32'h0, 1'b0);
    smp();
    chk("t3_rgnt", 64'(bus.gnt_o), 64'h1);
    chk("t3_swe", 64'(bus.sram_we_o), 64'h1);
    chk("t3_swd", 64'(bus.sram_wdata_o), 64'hDEADBEEF);
    chk("t3_sbe", 64'(bus.sram_be_o), 64'hF);
    chk("t3_sad", 64'(bus.sram_addr_o), 64'h20);
    tick();
    clr();
    smp();
    chk("t3_rcs", 64'(bus.sram_cs_o), 64'h1);
    chk("t3_rwe", 64'(bus.sram_we_o), 64'h0);
    tick();
    smp();
    chk("t3_nowrv", 64'(bus.rvalid_o), 64'h0);
    chk("t3_idlecs", 64'(bus.sram_cs_o), 64'h0);
    chk("t3_idlebe", 64'(bus.sram_be_o), 64'h0);
    chk("t3_idlead", 64'(bus.sram_addr_o), 64'h20);
    tick();
    smp();
    chk("t3_rv", 64'(bus.rvalid_o), 64'h1);
    chk("t3_rd", 64'(bus.rdata_o), 64'hDEADBEEF);

    // back-to-back reads from both requesters
    tick();
    setreq(0, 1'b0, 16'h0030, 32'h0, 1'b0);
    smp();
    chk("t4_g0", 64'(bus.gnt_o), 64'h1);
    tick();
    clr();
    setreq(1, 1'b0, 16'h0031, 32'h0, 1'b0);
    smp();
    chk("t4_g1", 64'(bus.gnt_o), 64'h2);
    tick();
    clr();
    tick();
    smp();
    chk("t4_rv0", 64'(bus.rvalid_o), 64'h1);
    chk("t4_rd0", 64'(bus.rdata_o), 64'(memf(48)));
    tick();
    smp();
    chk("t4_rv1", 64'(bus.rvalid_o), 64'h2);
    chk("t4_rd1", 64'(bus.rdata_o), 64'(memf(49)));
    repeat (3) tick();

    // lock run bounded by MAX_LOCK
    do_reset();
`ifdef SRAM_ARB_LOCK_EN
    g5[0] = 2'b01; g5[1] = 2'b01; g5[2] = 2'b01;
    g5[3] = 2'b10; g5[4] = 2'b01;
`else
    g5[0] = 2'b01; g5[1] = 2'b10; g5[2] = 2'b01;
    g5[3] = 2'b10; g5[4] = 2'b01;
`endif
    tick();
    setreq(0, 1'b0, 16'h0050, 32'h0, 1'b1);
    setreq(1, 1'b0, 16'h0051, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      smp();
      chk($sformatf("t5_gnt%0d", i),
          64'(bus.gnt_o), 64'(g5[i]));
    end
    tick();
    clr();
    repeat (5) tick();

    // reset kills an in-flight read
    do_reset();
    tick();
    setreq(0, 1'b0, 16'h0060, 32'h0, 1'b0);
    smp();
    chk("t6_gnt", 64'(bus.gnt_o), 64'h1);
    tick();
    smp();
    chk("t6_cs", 64'(bus.sram_cs_o), 64'h1);
    #1;
    rst_ni = 1'b0;
    sbq.delete();
    #1;
    chk("t6_cs0", 64'(bus.sram_cs_o), 64'h0);
    chk("t6_gnt0", 64'(bus.gnt_o), 64'h0);
    chk("t6_rv0", 64'(bus.rvalid_o), 64'h0);
    n0 = nret;
    @(posedge clk_i);
    #1;
    clr();
    rst_ni = 1'b1;
    repeat (6) tick();
    smp();
    chk("t6_noret", 64'(nret - n0), 64'd0);
    chk("t6_sbq", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
